// File: rtl/dcsformer_host_if.sv
// Stream port between the DCSformer host driver (master) and the accelerator (slave):
// matrix stream, weight request/stream and result stream.
interface dcsformer_host_if;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        w_ready;
  logic        w_valid;
  logic [7:0]  w_data;
  logic        o_valid;
  logic [31:0] o_data;

  modport master (
    output i_valid, i_data, w_valid, w_data,
    input  w_ready, o_valid, o_data
  );

  modport slave (
    input  i_valid, i_data, w_valid, w_data,
    output w_ready, o_valid, o_data
  );
endinterface

// File: rtl/dcsformer_host.sv
// Host driver for the DCSformer accelerator: streams a 128-byte matrix and 8 weights, captures 8 results.
// Optional watchdog (parameter TIMEOUT, WAIT_W / RECV_O stall detection) enabled by DCS_HOST_TIMEOUT_EN.
module dcsformer_host
`ifdef DCS_HOST_TIMEOUT_EN
  #(parameter int TIMEOUT = 1024)
`endif
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_en,
  input  logic [7:0]              ld_addr,
  input  logic [7:0]              ld_data,
  input  logic                    start,
  input  logic [2:0]              rd_addr,
  output logic [31:0]             rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  dcsformer_host_if.master        acc
);

  localparam int I_LEN = 128;
  localparam int W_LEN = 8;
  localparam int O_LEN = 8;

  typedef enum logic [2:0] {IDLE, SEND_I, WAIT_W, SEND_W, RECV_O, ERR} state_t;

  state_t      state_reg, state_next;
  logic [6:0]  cnt_reg, cnt_next;
  logic [7:0]  i_buf [I_LEN];
  logic [7:0]  w_buf [W_LEN];
  logic [31:0] res_reg [O_LEN];

  logic        i_valid_reg, i_valid_next;
  logic [7:0]  i_data_reg, i_data_next;
  logic        w_valid_reg, w_valid_next;
  logic [7:0]  w_data_reg, w_data_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [31:0] rd_data_reg;

  logic        capture, last_capture, timeout_hit, job_start;

  assign capture      = (state_reg == RECV_O) && acc.o_valid;
  assign last_capture = capture && (cnt_reg == 7'(O_LEN - 1));
  assign job_start    = (state_reg == IDLE) && start;

`ifdef DCS_HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_reg;
  logic            err_reg;

  // Counts stall cycles: waiting for w_ready, or for the next result word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_reg <= '0;
    end else if ((state_reg == WAIT_W && !acc.w_ready) ||
                 (state_reg == RECV_O && !acc.o_valid)) begin
      wd_reg <= wd_reg + 1'b1;
    end else begin
      wd_reg <= '0;
    end
  end

  assign timeout_hit = (wd_reg == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= (state_next == ERR);
    end
  end

  assign err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; cnt indexes the byte/word of the current phase
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SEND_I;
          cnt_next   = '0;
        end
      end
      SEND_I: begin
        if (cnt_reg == 7'(I_LEN - 1)) begin
          state_next = WAIT_W;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_W: begin
        if (acc.w_ready) begin
          state_next = SEND_W;
          cnt_next   = '0;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      SEND_W: begin
        if (cnt_reg == 7'(W_LEN - 1)) begin
          state_next = RECV_O;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RECV_O: begin
        if (capture) begin
          if (last_capture) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output logic: computed from the next state so every output is a flop.
  always_comb begin
    i_valid_next = (state_next == SEND_I);
    i_data_next  = i_valid_next ? i_buf[cnt_next] : 8'h00;
    w_valid_next = (state_next == SEND_W);
    w_data_next  = w_valid_next ? w_buf[cnt_next[2:0]] : 8'h00;
    busy_next    = (state_next inside {SEND_I, WAIT_W, SEND_W, RECV_O});
    done_next    = last_capture;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_valid_reg <= 1'b0;
      i_data_reg  <= 8'h00;
      w_valid_reg <= 1'b0;
      w_data_reg  <= 8'h00;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      i_valid_reg <= i_valid_next;
      i_data_reg  <= i_data_next;
      w_valid_reg <= w_valid_next;
      w_data_reg  <= w_data_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // Load buffers keep their contents across reset; frozen while a job runs.
  always_ff @(posedge clk) begin
    if (ld_en && !busy_reg) begin
      if (!ld_addr[7]) begin
        i_buf[ld_addr[6:0]] <= ld_data;
      end else if (ld_addr[6:3] == 4'd0) begin
        w_buf[ld_addr[2:0]] <= ld_data;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < O_LEN; gi++) begin : g_res
      always_ff @(posedge clk) begin
        if (rst || job_start) begin
          res_reg[gi] <= 32'h0;
        end else if (capture && cnt_reg[2:0] == 3'(gi)) begin
          res_reg[gi] <= acc.o_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= 32'h0;
    end else begin
      rd_data_reg <= res_reg[rd_addr];
    end
  end

  assign acc.i_valid = i_valid_reg;
  assign acc.i_data  = i_data_reg;
  assign acc.w_valid = w_valid_reg;
  assign acc.w_data  = w_data_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign rd_data     = rd_data_reg;

endmodule

// File: tb/tb_dcsformer_host.sv
// Directed self-checking bench for dcsformer_host; acts as system loader and accelerator responder.
// Watchdog checks adapt to DCS_HOST_TIMEOUT_EN (TIMEOUT overridden to 16 when defined).
module tb_dcsformer_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'h00;
  logic [7:0]  ld_data = 8'h00;
  logic        start = 1'b0;
  logic [2:0]  rd_addr = 3'd0;
  logic [31:0] rd_data;
  logic        busy, done, err;

  dcsformer_host_if acc_if ();

  always #5 clk = ~clk;

`ifdef DCS_HOST_TIMEOUT_EN
  dcsformer_host #(.TIMEOUT(16)) dut (
`else
  dcsformer_host dut (
`endif
    .clk     (clk),
    .rst     (rst),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .acc     (acc_if.master)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Stream monitor: logs the latest i/w bursts and counts done pulses.
  int         i_cnt = 0, w_cnt = 0, done_cnt = 0, idle_bad = 0;
  logic       i_prev = 1'b0, w_prev = 1'b0;
  logic [7:0] i_log [128];
  logic [7:0] w_log [8];

  always @(negedge clk) begin
    if (acc_if.i_valid) begin
      if (!i_prev) i_cnt = 0;
      if (i_cnt < 128) i_log[i_cnt] = acc_if.i_data;
      i_cnt++;
    end else if (acc_if.i_data != 8'h00) begin
      idle_bad++;
    end
    if (acc_if.w_valid) begin
      if (!w_prev) w_cnt = 0;
      if (w_cnt < 8) w_log[w_cnt] = acc_if.w_data;
      w_cnt++;
    end else if (acc_if.w_data != 8'h00) begin
      idle_bad++;
    end
    if (done) done_cnt++;
    i_prev = acc_if.i_valid;
    w_prev = acc_if.w_valid;
  end

  task automatic load_buffers();
    for (int a = 0; a < 136; a++) begin
      ld_en   = 1'b1;
      ld_addr = 8'(a);
      ld_data = (a < 128) ? 8'(a) : 8'(8'hA0 + (a - 128));
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  task automatic run_job(input string nm, input int gap, input bit disturb);
    int t;
    int bad;
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_first_byte"}, {23'd0, acc_if.i_valid, acc_if.i_data}, {23'd0, 1'b1, 8'h00});
    t = 0;
    while (acc_if.i_valid && t < 300) begin
      if (disturb && t == 10) begin
        acc_if.w_ready = 1'b1;
        ld_en = 1'b1; ld_addr = 8'd5; ld_data = 8'hEE;
      end else begin
        acc_if.w_ready = 1'b0;
        ld_en = 1'b0;
      end
      if (t == 20) check({nm, "_busy_send_i"}, 32'(busy), 32'd1);
      @(negedge clk);
      t++;
    end
    acc_if.w_ready = 1'b0;
    ld_en = 1'b0;
    repeat (2) @(negedge clk);
    acc_if.w_ready = 1'b1;
    @(negedge clk);
    acc_if.w_ready = 1'b0;
    check({nm, "_w_valid_start"}, 32'(acc_if.w_valid), 32'd1);
    t = 0;
    while (acc_if.w_valid && t < 20) begin
      start = disturb && (t == 3);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) repeat (gap) @(negedge clk);
      acc_if.o_valid = 1'b1;
      acc_if.o_data  = 32'h11111111 * k;
      @(negedge clk);
      acc_if.o_valid = 1'b0;
      acc_if.o_data  = 32'h0;
    end
    check({nm, "_done_pulse"}, {30'd0, done, busy}, {30'd0, 1'b1, 1'b0});
    @(negedge clk);
    check({nm, "_done_low"}, 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    check({nm, "_i_count"}, 32'(i_cnt), 32'd128);
    bad = 0;
    for (int k = 0; k < 128; k++) if (i_log[k] !== 8'(k)) bad++;
    check({nm, "_i_bytes_bad"}, 32'(bad), 32'd0);
    check({nm, "_i_byte5"}, 32'(i_log[5]), 32'd5);
    check({nm, "_w_count"}, 32'(w_cnt), 32'd8);
    bad = 0;
    for (int k = 0; k < 8; k++) if (w_log[k] !== 8'(8'hA0 + k)) bad++;
    check({nm, "_w_bytes_bad"}, 32'(bad), 32'd0);
    check({nm, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({nm, "_busy_after"}, 32'(busy), 32'd0);
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      @(negedge clk);
      check($sformatf("%s_rd%0d", nm, k), rd_data, 32'h11111111 * k);
    end
    $display("[TB] job %s complete (gap=%0d disturb=%0d)", nm, gap, disturb);
  endtask

  initial begin
    int t;
    acc_if.w_ready = 1'b0;
    acc_if.o_valid = 1'b0;
    acc_if.o_data  = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {acc_if.i_valid, acc_if.w_valid, busy, done, err, 3'd0, acc_if.i_data, acc_if.w_data},
          32'h0);
    check("reset_rd_data", rd_data, 32'h0);
    rst = 1'b0;
    load_buffers();
    $display("[TB] buffers loaded");

    run_job("basic", 0, 1'b0);
    run_job("gap2", 2, 1'b0);
    run_job("disturb", 1, 1'b1);
    run_job("after_disturb", 0, 1'b0);

    // Reset in the middle of the matrix stream
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (acc_if.i_data != 8'd60 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("midrst_reached_byte60", 32'(acc_if.i_data), 32'd60);
    rst = 1'b1;
    rd_addr = 3'd3;
    @(negedge clk);
    check("midrst_i_valid", 32'(acc_if.i_valid), 32'd0);
    check("midrst_flags", {29'd0, busy, done, err}, 32'd0);
    check("midrst_rd_data", rd_data, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_res_cleared", rd_data, 32'h0);
    $display("[TB] mid-job reset complete");

    // Watchdog: w_ready never arrives
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (acc_if.i_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
`ifdef DCS_HOST_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check("wd_before_limit", {30'd0, err, busy}, {30'd0, 1'b0, 1'b1});
    @(negedge clk);
    check("wd_at_limit", {30'd0, err, busy}, {30'd0, 1'b1, 1'b0});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("wd_start_ignored", {29'd0, acc_if.i_valid, err, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
`else
    repeat (40) @(negedge clk);
    check("nowd_still_waiting", {30'd0, err, busy}, {30'd0, 1'b0, 1'b1});
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("wd_cleared_by_reset", {30'd0, err, busy}, 32'd0);
    $display("[TB] watchdog scenario complete");

    check("idle_data_zero", 32'(idle_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
